alu_shift_wb: RTL and testbench

ALU_SHIFT_WB -- requirements
Module: alu_shift_wb

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_wb_fifo.sv | 59 +++++
 rtl/alu_shift_wb.sv | 98 +++++++++
 tb/tb_alu_shift_wb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared shift-ALU definitions: opcode encodings and flag-register bit positions.
package alu_pkg;

  localparam logic [3:0] OP_SHL = 4'b0000;
  localparam logic [3:0] OP_SHR = 4'b0001;
  localparam logic [3:0] OP_SAR = 4'b0010;
  localparam logic [3:0] OP_SAL = 4'b0011;

  // Flag register is ordered {N,Z,C,V}.
  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR) || (op == OP_SAL);
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Writeback output buffer: FIFO with power-of-two depth; head output holds the last popped
// value while empty.
module alu_wb_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] last_q;
  logic             push, pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign pop     = pop_i && valid_o;
  assign push    = push_i && (!full_o || pop);
  assign data_o  = valid_o ? mem_q[rptr_q] : last_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        last_q <= mem_q[rptr_q];
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_shift_wb.sv
// Shift-ALU writeback stage: buffers results through alu_wb_fifo and maintains the
// architectural {N,Z,C,V} flags, sticky overflow and invalid-opcode pulse.
module alu_shift_wb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_shamt,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_c,
  input  logic             in_v,
  input  logic             in_z,
  input  logic             in_n,
  input  logic             flag_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_op,
  output logic [3:0]       flags,
  output logic             sticky_v,
  output logic             op_err
);

  logic             fifo_full, fifo_valid;
  logic [WIDTH+3:0] fifo_data;
  logic             accept, pop, op_ok;
  logic [3:0]       flags_q, flags_d;
  logic             sticky_q, sticky_d;
  logic             op_err_q, op_err_d;

  assign pop      = out_valid && out_ready;
  assign in_ready = !rst && (!fifo_full || pop);
  assign accept   = in_valid && in_ready;
  assign op_ok    = op_is_valid(in_op);

  alu_wb_fifo #(
    .WIDTH (WIDTH + 4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (accept),
    .data_i  ({in_op, in_result}),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .valid_o (fifo_valid),
    .data_o  (fifo_data)
  );

  always_comb begin
    flags_d  = flags_q;
    sticky_d = sticky_q;
    op_err_d = accept && !op_ok;
    if (accept && op_ok) begin
      flags_d[FLAG_N] = in_n;
      flags_d[FLAG_Z] = in_z;
      flags_d[FLAG_V] = in_v;
      if (in_op == OP_SAL) begin
        flags_d[FLAG_C] = 1'b0;
      end else if (in_shamt != '0) begin
        flags_d[FLAG_C] = in_c;
      end
    end
    // Set has priority over a simultaneous clear.
    if (accept && op_ok && in_v) begin
      sticky_d = 1'b1;
    end else if (flag_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= '0;
      sticky_q <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      op_err_q <= op_err_d;
    end
  end

  // Outputs are forced to zero while rst is high, even before the first reset edge.
  assign out_valid  = fifo_valid && !rst;
  assign out_result = rst ? '0 : fifo_data[WIDTH-1:0];
  assign out_op     = rst ? '0 : fifo_data[WIDTH+3:WIDTH];
  assign flags      = rst ? '0 : flags_q;
  assign sticky_v   = sticky_q && !rst;
  assign op_err     = op_err_q && !rst;

endmodule

// File: tb/tb_alu_shift_wb.sv
// Directed self-checking bench for alu_shift_wb with hand-computed expectations.
module tb_alu_shift_wb;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_shamt, in_result;
  logic             in_c, in_v, in_z, in_n;
  logic             flag_clr;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_op, flags;
  logic             sticky_v, op_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_shift_wb #(
    .WIDTH (WIDTH),
    .DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_shamt   (in_shamt),
    .in_result  (in_result),
    .in_c       (in_c),
    .in_v       (in_v),
    .in_z       (in_z),
    .in_n       (in_n),
    .flag_clr   (flag_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .flags      (flags),
    .sticky_v   (sticky_v),
    .op_err     (op_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] shamt, input logic [31:0] res,
                       input logic c, input logic v, input logic z, input logic n);
    in_valid  = 1'b1;
    in_op     = op;
    in_shamt  = shamt;
    in_result = res;
    in_c      = c;
    in_v      = v;
    in_z      = z;
    in_n      = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    in_op = '0; in_shamt = '0; in_result = '0;
    in_c = 1'b0; in_v = 1'b0; in_z = 1'b0; in_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", flags, 0);
    check("rst_sticky", sticky_v, 0);
    check("rst_op_err", op_err, 0);
    check("rst_out_result", out_result, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // shr with carry out
    out_ready = 1'b1;
    drive(4'b0001, 1, 32'h0000_0001, 1, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    check("shr_flags", flags, 4'b0010);
    check("shr_out_valid", out_valid, 1);
    check("shr_out_result", out_result, 32'h0000_0001);
    check("shr_out_op", out_op, 4'b0001);
    tick();
    check("empty_out_valid", out_valid, 0);
    check("empty_hold_result", out_result, 32'h0000_0001);
    check("empty_hold_op", out_op, 4'b0001);

    // zero shift keeps C
    drive(4'b0001, 0, 32'h0, 0, 0, 1, 0);
    tick();
    in_valid = 1'b0;
    check("shamt0_flags", flags, 4'b0110);

    // oversized shift amount takes in_c as given
    drive(4'b0000, 32, 32'h0, 0, 0, 1, 0);
    tick();
    check("shl_big_flags", flags, 4'b0100);
    drive(4'b0010, 4, 32'hF800_0000, 0, 0, 0, 1);
    tick();
    in_valid = 1'b0;
    check("sar_flags", flags, 4'b1000);
    check("sar_out_result", out_result, 32'hF800_0000);
    check("sar_out_op", out_op, 4'b0010);
    tick();

    // sal overflow, sticky set/clear priority
    drive(4'b0011, 1, 32'h8000_0000, 1, 1, 0, 1);
    tick();
    check("sal_flags", flags, 4'b1001);
    check("sal_sticky", sticky_v, 1);
    drive(4'b0000, 1, 32'h0000_0002, 0, 1, 0, 0);
    flag_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    check("clr_set_sticky", sticky_v, 1);
    check("clr_set_flags", flags, 4'b0001);
    tick();
    flag_clr = 1'b0;
    check("lone_clr_sticky", sticky_v, 0);
    check("lone_clr_flags", flags, 4'b0001);
    tick();

    // invalid opcode
    drive(4'b0111, 3, 32'h1234_5678, 1, 1, 1, 1);
    tick();
    in_valid = 1'b0;
    check("bad_op_err", op_err, 1);
    check("bad_op_flags", flags, 4'b0001);
    check("bad_op_sticky", sticky_v, 0);
    check("bad_op_out_op", out_op, 4'b0111);
    check("bad_op_out_result", out_result, 32'h1234_5678);
    tick();
    check("bad_op_pulse_end", op_err, 0);
    check("bad_op_popped", out_valid, 0);

    // full buffer, simultaneous push/pop
    out_ready = 1'b0;
    drive(4'b0000, 1, 32'h0000_000A, 0, 0, 0, 0);
    #1;
    check("fill_ready0", in_ready, 1);
    tick();
    drive(4'b0000, 1, 32'h0000_000B, 0, 0, 0, 0);
    tick();
    drive(4'b0000, 1, 32'h0000_000C, 0, 0, 0, 0);
    #1;
    check("full_no_ready", in_ready, 0);
    tick();
    check("full_head_a", out_result, 32'h0000_000A);
    out_ready = 1'b1;
    #1;
    check("full_pop_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("still_full", in_ready, 0);
    check("order_b", out_result, 32'h0000_000B);
    out_ready = 1'b1;
    tick();
    check("order_c", out_result, 32'h0000_000C);
    check("order_c_valid", out_valid, 1);
    tick();
    check("drained", out_valid, 0);
    check("drained_hold", out_result, 32'h0000_000C);

    // reset mid-stream
    out_ready = 1'b0;
    drive(4'b0001, 1, 32'h0000_0011, 1, 0, 0, 1);
    tick();
    drive(4'b0001, 1, 32'h0000_0022, 1, 0, 0, 1);
    tick();
    in_valid = 1'b0;
    check("pre_rst_flags", flags, 4'b1010);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("after_rst_out_valid", out_valid, 0);
    check("after_rst_flags", flags, 0);
    check("after_rst_in_ready", in_ready, 1);
    check("after_rst_out_result", out_result, 0);
    tick();
    check("after_rst_still_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
